uart_mmio_fifo: RTL and testbench

Memory-mapped UART front-end between the CPU data-memory port and the UART byte handshake interface. Buffers transmit and receive bytes in parametrised FIFOs so software need not poll per byte. Provides sticky error flags and a level interrupt. Supersedes direct CPU-to-UART handshake wiring at the top level.

---
 rtl/uart_mmio_fifo_pkg.sv | 43 ++++
 rtl/uart_mmio_fifo_sync_fifo.sv | 72 +++++++
 rtl/uart_mmio_fifo.sv | 178 +++++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_fifo_pkg.sv
// Shared definitions for the memory-mapped UART FIFO front-end.
// Contents: register offsets inside the 32-byte window, bit positions
// of the STATUS / ERR / IE registers, and a constant clog2 helper used
// to size FIFO pointers and counters.
package uart_mmio_fifo_pkg;

  // Register offsets (byte offsets, low two bits always zero)
  localparam logic [4:0] OFF_STATUS = 5'h00;
  localparam logic [4:0] OFF_RXDATA = 5'h04;
  localparam logic [4:0] OFF_TXDATA = 5'h08;
  localparam logic [4:0] OFF_ERR    = 5'h0C;
  localparam logic [4:0] OFF_IE     = 5'h10;
  localparam logic [4:0] OFF_COUNT  = 5'h14;

  // STATUS bit positions
  localparam int ST_TX_NOT_FULL  = 0;
  localparam int ST_RX_NOT_EMPTY = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_RX_FULL      = 3;

  // ERR bit positions (sticky, write-one-to-clear)
  localparam int ERR_TX_OVERFLOW  = 0;
  localparam int ERR_RX_OVERRUN   = 1;
  localparam int ERR_RX_UNDERFLOW = 2;

  // IE bit positions
  localparam int IE_RX = 0;
  localparam int IE_TX = 1;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_mmio_fifo_sync_fifo.sv
// Single-clock FIFO with drop-on-full behaviour.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write request and data; ignored (dropped) when full
//   pop             read request; ignored when empty
//   head_data       oldest entry, combinational from storage
//   full, empty     status of the registered (pre-edge) state
//   count           current number of entries
//   count_next      number of entries after the coming edge
//   overflow        pulse: push requested while full
// Full/empty are evaluated on pre-edge state, so a pop in the same cycle
// never makes room for a push into a full FIFO. A push into an empty FIFO
// shows up at head_data only after the edge (no fall-through).
module sync_fifo
  import uart_mmio_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
  localparam int CW = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_next,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full       = (count_r == CW'(DEPTH));
  assign empty      = (count_r == CW'(0));
  assign count      = count_r;
  assign head_data  = mem_r[rd_ptr_r];
  assign push_ok_s  = push & ~full;
  assign pop_ok_s   = pop & ~empty;
  assign overflow   = push & full;
  assign count_next = count_r + CW'(push_ok_s) - CW'(pop_ok_s);

  // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next;
    end
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front-end with transmit and receive FIFOs.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   addr, re, we, wdata      CPU data-memory port (byte address, read
//                            enable, byte write enables, write data)
//   rdata                    registered read data, valid the cycle after re
//   hit                      combinational window decode
//   uart_tx_data/valid/ready byte stream towards the UART transmitter
//   uart_rx_data/valid/ready byte stream from the UART receiver
//   irq                      registered level interrupt
module uart_mmio_fifo
  import uart_mmio_fifo_pkg::*;
#(
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic        irq
);

  localparam int TX_CW = clog2(TX_DEPTH) + 1;
  localparam int RX_CW = clog2(RX_DEPTH) + 1;

  logic [4:0]       off_s;
  logic             rd_s;
  logic             wr_s;
  logic             tx_push_s;
  logic             tx_pop_s;
  logic             rx_pop_s;
  logic             rx_read_s;
  logic             tx_full_s;
  logic             tx_empty_s;
  logic             rx_full_s;
  logic             rx_empty_s;
  logic             tx_overflow_s;
  logic             rx_overflow_s;
  logic [7:0]       rx_head_s;
  logic [TX_CW-1:0] tx_count_s;
  logic [TX_CW-1:0] tx_count_nx_s;
  logic [RX_CW-1:0] rx_count_s;
  logic [RX_CW-1:0] rx_count_nx_s;
  logic [2:0]       err_set_s;
  logic [2:0]       err_clr_s;
  logic [2:0]       err_nx_s;
  logic [1:0]       ie_nx_s;
  logic             irq_nx_s;
  logic [31:0]      rdata_nx_s;
  logic [2:0]       err_r;
  logic [1:0]       ie_r;
  logic             irq_r;
  logic [31:0]      rdata_r;
  logic             unused_s;

  assign hit           = (addr[31:5] == ADDR_BASE[31:5]);
  assign off_s         = {addr[4:2], 2'b00};
  assign rd_s          = hit & re;
  assign wr_s          = hit & (|we);
  assign tx_push_s     = wr_s & (off_s == OFF_TXDATA);
  assign rx_read_s     = rd_s & (off_s == OFF_RXDATA);
  assign rx_pop_s      = rx_read_s & ~rx_empty_s;
  assign uart_tx_valid = ~tx_empty_s;
  assign tx_pop_s      = uart_tx_valid & uart_tx_ready;
  assign uart_rx_ready = ~rx_full_s;
  assign rdata         = rdata_r;
  assign irq           = irq_r;
  assign unused_s      = ^{addr[1:0], wdata[31:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (tx_push_s),
    .push_data  (wdata[7:0]),
    .pop        (tx_pop_s),
    .head_data  (uart_tx_data),
    .full       (tx_full_s),
    .empty      (tx_empty_s),
    .count      (tx_count_s),
    .count_next (tx_count_nx_s),
    .overflow   (tx_overflow_s)
  );

  // The receiver is offered the FIFO unconditionally; a byte arriving while full is dropped and flagged.
  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (uart_rx_valid),
    .push_data  (uart_rx_data),
    .pop        (rx_pop_s),
    .head_data  (rx_head_s),
    .full       (rx_full_s),
    .empty      (rx_empty_s),
    .count      (rx_count_s),
    .count_next (rx_count_nx_s),
    .overflow   (rx_overflow_s)
  );

  // Sticky error flags, interrupt enables and next interrupt level
  always_comb begin
    err_set_s                   = 3'b000;
    err_set_s[ERR_TX_OVERFLOW]  = tx_overflow_s;
    err_set_s[ERR_RX_OVERRUN]   = rx_overflow_s;
    err_set_s[ERR_RX_UNDERFLOW] = rx_read_s & rx_empty_s;
    if (wr_s && (off_s == OFF_ERR)) begin
      err_clr_s = wdata[2:0];
    end else begin
      err_clr_s = 3'b000;
    end
    // Set events are OR-ed in after the clear so they win a same-cycle race.
    err_nx_s = (err_r & ~err_clr_s) | err_set_s;
    if (wr_s && (off_s == OFF_IE)) begin
      ie_nx_s = wdata[1:0];
    end else begin
      ie_nx_s = ie_r;
    end
    irq_nx_s = (ie_nx_s[IE_RX] & (rx_count_nx_s != RX_CW'(0)))
             | (ie_nx_s[IE_TX] & (tx_count_nx_s == TX_CW'(0)))
             | (|err_nx_s);
  end

  // Read-data mux on pre-edge state; holds when there is no read
  always_comb begin
    rdata_nx_s = rdata_r;
    if (rd_s) begin
      rdata_nx_s = 32'h0000_0000;
      case (off_s)
        OFF_STATUS: begin
          rdata_nx_s[ST_TX_NOT_FULL]  = ~tx_full_s;
          rdata_nx_s[ST_RX_NOT_EMPTY] = ~rx_empty_s;
          rdata_nx_s[ST_TX_EMPTY]     = tx_empty_s;
          rdata_nx_s[ST_RX_FULL]      = rx_full_s;
        end
        OFF_RXDATA: begin
          if (rx_empty_s) begin
            rdata_nx_s = 32'h0000_0000;
          end else begin
            rdata_nx_s = {24'h00_0000, rx_head_s};
          end
        end
        OFF_ERR:    rdata_nx_s = {29'h0000_0000, err_r};
        OFF_IE:     rdata_nx_s = {30'h0000_0000, ie_r};
        OFF_COUNT:  rdata_nx_s = {16'h0000, 8'(rx_count_s), 8'(tx_count_s)};
        default:    rdata_nx_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_nx_s = rdata_r;
    end
  end

  // Control/status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r   <= 3'b000;
      ie_r    <= 2'b00;
      irq_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      err_r   <= err_nx_s;
      ie_r    <= ie_nx_s;
      irq_r   <= irq_nx_s;
      rdata_r <= rdata_nx_s;
    end
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Self-checking bench for uart_mmio_fifo: a queue-based reference model
// checked every negative edge, plus hand-computed directed expectations.
module tb_uart_mmio_fifo;

  localparam int          TXD  = 8;
  localparam int          RXD  = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = BASE;
  logic        re = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        hit;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = 8'h00;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  uart_mmio_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .ADDR_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .wdata(wdata),
    .rdata(rdata), .hit(hit),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_tx_q[$];
  logic [7:0]  m_rx_q[$];
  logic [2:0]  m_err;
  logic [1:0]  m_ie;
  logic        m_irq;
  logic [31:0] m_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tx_q.delete();
      m_rx_q.delete();
      m_err   = 3'b000;
      m_ie    = 2'b00;
      m_irq   = 1'b0;
      m_rdata = 32'h0;
    end else begin
      logic        mh;
      logic [4:0]  mo;
      int          txn;
      int          rxn;
      logic [2:0]  set;
      logic [2:0]  clr;
      mh  = (addr[31:5] == BASE[31:5]);
      mo  = addr[4:0] & 5'h1C;
      txn = m_tx_q.size();
      rxn = m_rx_q.size();
      set = 3'b000;
      clr = 3'b000;
      if (mh && re) begin
        case (mo)
          5'h00: m_rdata = {28'h0, (rxn == RXD), (txn == 0), (rxn > 0), (txn < TXD)};
          5'h04: m_rdata = (rxn > 0) ? {24'h0, m_rx_q[0]} : 32'h0;
          5'h0C: m_rdata = {29'h0, m_err};
          5'h10: m_rdata = {30'h0, m_ie};
          5'h14: m_rdata = {16'h0, 8'(rxn), 8'(txn)};
          default: m_rdata = 32'h0;
        endcase
        if (mo == 5'h04) begin
          if (rxn > 0) void'(m_rx_q.pop_front());
          else set[2] = 1'b1;
        end
      end
      if (txn > 0 && uart_tx_ready) void'(m_tx_q.pop_front());
      if (mh && (we != 4'h0)) begin
        if (mo == 5'h08) begin
          if (txn < TXD) m_tx_q.push_back(wdata[7:0]);
          else set[0] = 1'b1;
        end
        if (mo == 5'h0C) clr = wdata[2:0];
        if (mo == 5'h10) m_ie = wdata[1:0];
      end
      if (uart_rx_valid) begin
        if (rxn < RXD) m_rx_q.push_back(uart_rx_data);
        else set[1] = 1'b1;
      end
      m_err = (m_err & ~clr) | set;
      m_irq = (m_ie[0] && m_rx_q.size() > 0) || (m_ie[1] && m_tx_q.size() == 0) || (m_err != 3'b000);
    end
  end

  // Compare DUT against the model away from the active edge
  always @(negedge clk) begin
    chk("hit", 32'(hit), 32'(addr[31:5] == BASE[31:5]));
    chk("rdata", rdata, m_rdata);
    chk("irq", 32'(irq), 32'(m_irq));
    chk("tx_valid", 32'(uart_tx_valid), 32'(m_tx_q.size() > 0));
    if (m_tx_q.size() > 0) chk("tx_data", 32'(uart_tx_data), 32'(m_tx_q[0]));
    chk("rx_ready", 32'(uart_rx_ready), 32'(m_rx_q.size() < RXD));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [4:0] off, input logic [31:0] d);
    addr  = BASE + {27'd0, off};
    we    = 4'hF;
    wdata = d;
    tick();
    we    = 4'h0;
  endtask

  task automatic cpu_rd(input logic [4:0] off, output logic [31:0] d);
    addr = BASE + {27'd0, off};
    re   = 1'b1;
    tick();
    re   = 1'b0;
    d    = rdata;
  endtask

  task automatic rx_inject(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    tick();
    uart_rx_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          got;
    logic [7:0]  exp6 [3];
    exp6[0] = 8'hA2; exp6[1] = 8'hA3; exp6[2] = 8'hA4;

    // Reset, some traffic, then reset mid-traffic
    tick(); tick();
    rst = 1'b0;
    tick();
    cpu_wr(5'h08, 32'h55);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h66;
    cpu_wr(5'h10, 32'h3);
    uart_rx_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("irq_after_reset", 32'(irq), 32'h0);
    cpu_rd(5'h00, d); chk("status_reset", d, 32'h5);
    cpu_rd(5'h14, d); chk("count_reset", d, 32'h0);

    // TX overflow with transmitter stalled
    for (int i = 0; i < 9; i++) cpu_wr(5'h08, 32'h41 + i);
    cpu_rd(5'h14, d); chk("tx_count_full", d, 32'h8);
    cpu_rd(5'h0C, d); chk("err_tx_ovf", d, 32'h1);
    cpu_rd(5'h00, d); chk("status_tx_full", d, 32'h0);
    uart_tx_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 8; c++) begin
      if (uart_tx_valid) begin
        chk("tx_seq", 32'(uart_tx_data), 32'h41 + got);
        got++;
      end
      tick();
    end
    chk("tx_drained", got, 8);
    chk("tx_valid_empty", 32'(uart_tx_valid), 32'h0);
    uart_tx_ready = 1'b0;
    cpu_wr(5'h0C, 32'h1);
    cpu_rd(5'h0C, d); chk("err_cleared_tx", d, 32'h0);

    // RX reads including underflow
    rx_inject(8'h10); rx_inject(8'h20); rx_inject(8'h30);
    cpu_rd(5'h04, d); chk("rx_read0", d, 32'h10);
    cpu_rd(5'h04, d); chk("rx_read1", d, 32'h20);
    cpu_rd(5'h04, d); chk("rx_read2", d, 32'h30);
    cpu_rd(5'h04, d); chk("rx_read_empty", d, 32'h0);
    cpu_rd(5'h0C, d); chk("err_rx_udf", d, 32'h4);
    cpu_wr(5'h0C, 32'h4);
    cpu_rd(5'h0C, d); chk("err_udf_cleared", d, 32'h0);

    // RX overrun
    for (int i = 0; i < 9; i++) begin
      rx_inject(8'h80 + 8'(i));
      if (i == 7) chk("rx_ready_full", 32'(uart_rx_ready), 32'h0);
    end
    cpu_rd(5'h0C, d); chk("err_rx_ovr", d, 32'h2);
    cpu_rd(5'h14, d); chk("rx_count_full", d, 32'h0800);
    cpu_rd(5'h00, d); chk("status_rx_full", d, 32'hF);
    for (int i = 0; i < 8; i++) begin
      cpu_rd(5'h04, d); chk("rx_drain", d, 32'h80 + i);
    end
    cpu_wr(5'h0C, 32'h7);

    // RX interrupt
    cpu_wr(5'h10, 32'h1);
    chk("irq_idle", 32'(irq), 32'h0);
    rx_inject(8'h5A);
    chk("irq_rx_rise", 32'(irq), 32'h1);
    cpu_rd(5'h04, d);
    chk("irq_rx_data", d, 32'h5A);
    chk("irq_rx_fall", 32'(irq), 32'h0);

    // TX-empty interrupt, unmapped offset, off-window read holds rdata
    cpu_wr(5'h10, 32'h2);
    chk("irq_tx_empty", 32'(irq), 32'h1);
    cpu_rd(5'h10, d); chk("ie_readback", d, 32'h2);
    addr = 32'h1000_0004; re = 1'b1; tick(); re = 1'b0;
    chk("miss_hold", rdata, 32'h2);
    cpu_rd(5'h18, d); chk("unmapped_read", d, 32'h0);
    cpu_wr(5'h10, 32'h0);

    // Simultaneous CPU push and UART pop with three entries
    cpu_wr(5'h08, 32'hA1); cpu_wr(5'h08, 32'hA2); cpu_wr(5'h08, 32'hA3);
    uart_tx_ready = 1'b1;
    cpu_wr(5'h08, 32'hA4);
    uart_tx_ready = 1'b0;
    cpu_rd(5'h14, d); chk("tx_count_same", d, 32'h3);
    uart_tx_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (uart_tx_valid) begin
        chk("tx_order", 32'(uart_tx_data), 32'(exp6[got]));
        got++;
      end
      tick();
    end
    chk("tx_order_count", got, 3);
    uart_tx_ready = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
